// File: rtl/leaf_inject_sched.sv
// leaf_inject_sched: round-robin injection of NUM_REQ local requesters into one BFT leaf port,
// holding packets across resend, with retry accounting and a registered receive path.

// One requester's slice of the arbiter: it wins when it is valid and no valid requester sits
// between the rr pointer and itself in the cyclic scan order.
module leaf_inject_lane #(
  parameter int NUM_REQ    = 4,
  parameter int LANE       = 0,
  parameter int PTR_W      = 2,
  parameter int ADDR_W     = 4,
  parameter int payload_sz = 43
) (
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [PTR_W-1:0]             rr_ptr,
  input  logic                         grant_ok,
  input  logic [ADDR_W-1:0]            dest,
  input  logic [payload_sz-1:0]        payload,
  output logic                         ready,
  output logic [ADDR_W+payload_sz-1:0] pkt
);
  logic           ahead;
  logic           reached;
  logic [PTR_W:0] idx;

  always_comb begin
    ahead   = 1'b0;
    reached = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (idx == (PTR_W+1)'(LANE)) reached = 1'b1;
      else if (!reached)          ahead   = ahead | req_valid[idx[PTR_W-1:0]];
    end
    ready = grant_ok & req_valid[LANE] & ~ahead;
  end

  assign pkt = {dest, payload};
endmodule

module leaf_inject_sched #(
  parameter  int num_leaves = 16,
  parameter  int payload_sz = 43,
  parameter  int p_sz       = 48,
  parameter  int NUM_REQ    = 4,
  parameter  int MAX_RETRY  = 255,
  localparam int ADDR_W     = $clog2(num_leaves),
  localparam int PKT_W      = ADDR_W + payload_sz
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         inject_en,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_dest,
  input  logic [NUM_REQ*payload_sz-1:0] req_payload,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [p_sz-1:0]              pe_interface,
  input  logic                         resend,
  input  logic [p_sz-1:0]              interface_pe,
  output logic                         rx_valid,
  output logic [p_sz-2:0]              rx_data,
  output logic [15:0]                  sent_cnt,
  output logic [15:0]                  retry_cnt,
  output logic                         stall_err
);
  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_RETRY + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                          state, state_nxt;
  logic [PTR_W-1:0]                rr_ptr, rr_nxt, win_idx;
  logic [HOLD_W-1:0]               hold_cnt;
  logic                            grant_ok, grant, accept, retry;
  logic [NUM_REQ-1:0]              lane_rdy;
  logic [NUM_REQ-1:0][PKT_W-1:0]   lane_pkt;
  logic [PKT_W-1:0]                win_pkt;

  // A held packet under resend blocks new grants; an accepted one may be replaced back-to-back.
  assign grant_ok = reset_n & inject_en & ((state == IDLE) | ~resend);
  assign accept   = (state == SEND) & ~resend;
  assign retry    = (state == SEND) & resend;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    leaf_inject_lane #(
      .NUM_REQ(NUM_REQ), .LANE(i), .PTR_W(PTR_W), .ADDR_W(ADDR_W), .payload_sz(payload_sz)
    ) u_lane (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .grant_ok  (grant_ok),
      .dest      (req_dest[i*ADDR_W +: ADDR_W]),
      .payload   (req_payload[i*payload_sz +: payload_sz]),
      .ready     (lane_rdy[i]),
      .pkt       (lane_pkt[i])
    );
  end

  assign req_ready = lane_rdy;
  assign grant     = |lane_rdy;

  // Grant is one-hot, so an AND-OR mux picks the winner's packet.
  always_comb begin
    win_pkt = '0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (lane_rdy[i]) begin
        win_pkt = win_pkt | lane_pkt[i];
        win_idx = PTR_W'(i);
      end
    end
    rr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = SEND;
      SEND:    if (!resend && !grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_interface <= '0;
      rr_ptr       <= '0;
      hold_cnt     <= '0;
      sent_cnt     <= '0;
      retry_cnt    <= '0;
      stall_err    <= 1'b0;
    end else begin
      if (grant) begin
        pe_interface <= {1'b1, win_pkt};
        rr_ptr       <= rr_nxt;
      end else if (accept) begin
        pe_interface <= '0;
      end
      if (accept) begin
        sent_cnt <= sent_cnt + 16'd1;
        hold_cnt <= '0;
      end
      if (retry) begin
        if (retry_cnt != 16'hFFFF)             retry_cnt <= retry_cnt + 16'd1;
        if (hold_cnt != HOLD_W'(MAX_RETRY))    hold_cnt  <= hold_cnt + 1'b1;
        // This resend is the MAX_RETRY-th one for the held packet.
        if (hold_cnt >= HOLD_W'(MAX_RETRY - 1)) stall_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= interface_pe[p_sz-1];
      if (interface_pe[p_sz-1]) rx_data <= interface_pe[p_sz-2:0];
    end
  end
endmodule

// File: tb/tb_leaf_inject_sched.sv
// Scoreboard bench for leaf_inject_sched: a queue of granted packets is drained by a monitor
// that checks the network port, counters and the receive path every cycle.
`timescale 1ns/1ps
module tb_leaf_inject_sched;
  localparam int NR = 4, AW = 4, PL = 43, PS = 48, MR = 4;

  logic             clk = 1'b0, reset_n = 1'b1, inject_en = 1'b0, resend = 1'b0;
  logic [NR-1:0]    req_valid = '0, req_ready;
  logic [NR*AW-1:0] req_dest = '0;
  logic [NR*PL-1:0] req_payload = '0;
  logic [PS-1:0]    pe_interface, interface_pe = '0;
  logic             rx_valid, stall_err;
  logic [PS-2:0]    rx_data;
  logic [15:0]      sent_cnt, retry_cnt;

  // stimulus staging, applied at each falling edge by tick()
  logic             s_rst = 1'b1, s_inj = 1'b1, s_resend = 1'b0;
  logic [NR-1:0]    s_valid = '0;
  logic [NR*AW-1:0] s_dest = '0;
  logic [NR*PL-1:0] s_pay = '0;
  logic [PS-1:0]    s_ipe = '0;

  int checks = 0, errors = 0;
  logic [PS-2:0] exp_q[$];
  int   rr = 0;
  int   e_sent = 0, e_retry = 0, e_hold = 0;
  logic e_stall = 1'b0, e_rxv = 1'b0;
  logic [PS-2:0] e_rxd = '0;

  leaf_inject_sched #(
    .num_leaves(16), .payload_sz(PL), .p_sz(PS), .NUM_REQ(NR), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .inject_en(inject_en),
    .req_valid(req_valid), .req_dest(req_dest), .req_payload(req_payload),
    .req_ready(req_ready), .pe_interface(pe_interface), .resend(resend),
    .interface_pe(interface_pe), .rx_valid(rx_valid), .rx_data(rx_data),
    .sent_cnt(sent_cnt), .retry_cnt(retry_cnt), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] d, input logic [PL-1:0] p);
    s_dest[i*AW +: AW] = d;
    s_pay[i*PL +: PL]  = p;
  endtask

  // Apply staged inputs, then predict this cycle's grant from the round-robin rule.
  task automatic tick();
    logic [NR-1:0] er;
    @(negedge clk);
    reset_n = s_rst; inject_en = s_inj; req_valid = s_valid; req_dest = s_dest;
    req_payload = s_pay; resend = s_resend; interface_pe = s_ipe;
    #2;
    er = '0;
    if (!reset_n) rr = 0;
    else if (inject_en && (exp_q.size() == 0 || !resend)) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (rr + k) % NR;
        if (req_valid[i]) begin
          er[i] = 1'b1;
          exp_q.push_back({req_dest[i*AW +: AW], req_payload[i*PL +: PL]});
          rr = (i + 1) % NR;
          break;
        end
      end
    end
    check("req_ready", 64'(req_ready), 64'(er));
  endtask

  task automatic do_reset();
    s_rst = 1'b0; s_valid = '0; s_resend = 1'b0; s_ipe = '0;
    tick();
    s_rst = 1'b1;
    tick();
  endtask

  // Monitor: the queue head is the packet that must be on the port; a cycle without resend retires it.
  initial forever begin
    @(negedge clk); #1;
    if (!reset_n) begin
      exp_q.delete();
      e_sent = 0; e_retry = 0; e_hold = 0; e_stall = 1'b0; e_rxv = 1'b0; e_rxd = '0;
    end
    if (exp_q.size() != 0) check("pe_interface", 64'(pe_interface), 64'({1'b1, exp_q[0]}));
    else                   check("pe_idle", 64'(pe_interface), 64'd0);
    check("sent_cnt", 64'(sent_cnt), 64'(e_sent));
    check("retry_cnt", 64'(retry_cnt), 64'(e_retry));
    check("stall_err", 64'(stall_err), 64'(e_stall));
    check("rx_valid", 64'(rx_valid), 64'(e_rxv));
    check("rx_data", 64'(rx_data), 64'(e_rxd));
    if (reset_n) begin
      if (exp_q.size() != 0) begin
        if (resend) begin
          if (e_retry < 65535) e_retry++;
          e_hold++;
          if (e_hold >= MR) e_stall = 1'b1;
        end else begin
          void'(exp_q.pop_front());
          e_sent = (e_sent + 1) % 65536;
          e_hold = 0;
        end
      end
      e_rxv = interface_pe[PS-1];
      if (interface_pe[PS-1]) e_rxd = interface_pe[PS-2:0];
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    s_rst = 1'b0;
    tick();
    do_reset();

    // T1: single request, latency and count
    set_req(0, 4'd5, 43'h1234);
    s_valid = 4'b0001; tick();
    s_valid = '0; tick(); tick();
    check("t1_sent", 64'(sent_cnt), 64'd1);

    // T2: all requesting, strict rotation
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(i + 8), PL'(i * 17 + 3));
    s_valid = 4'b1111;
    repeat (8) tick();
    s_valid = '0; tick(); tick();
    check("t2_sent", 64'(sent_cnt), 64'd8);

    // T3: three resend cycles then accept
    do_reset();
    s_valid = 4'b0001; tick();
    s_valid = '0; s_resend = 1'b1; repeat (3) tick();
    s_resend = 1'b0; tick(); tick();
    check("t3_retry", 64'(retry_cnt), 64'd3);
    check("t3_sent", 64'(sent_cnt), 64'd1);

    // T4: stuck resend trips stall_err on the MAX_RETRY-th cycle
    do_reset();
    s_valid = 4'b0001; tick();
    s_valid = '0; s_resend = 1'b1; repeat (4) tick();
    check("t4_stall_early", 64'(stall_err), 64'd0);
    tick();
    check("t4_stall", 64'(stall_err), 64'd1);
    check("t4_held", 64'(pe_interface[PS-1]), 64'd1);
    s_resend = 1'b0; tick(); tick();
    check("t4_sent", 64'(sent_cnt), 64'd1);

    // T5: injection disabled, then grants 1 and 2
    do_reset();
    s_inj = 1'b0; s_valid = 4'b0110; repeat (3) tick();
    s_inj = 1'b1; tick(); tick();
    s_valid = '0; tick(); tick();
    check("t5_sent", 64'(sent_cnt), 64'd2);

    // T6: receive pulse, then reset while a packet is held
    do_reset();
    s_ipe = {1'b1, 4'd3, 43'h7}; tick();
    s_ipe = '0; tick();
    check("t6_rx_valid", 64'(rx_valid), 64'd1);
    check("t6_rx_data", 64'(rx_data), 64'({4'd3, 43'h7}));
    s_valid = 4'b0001; s_resend = 1'b1; tick();
    s_rst = 1'b0; tick();
    check("t6_rst_pe", 64'(pe_interface), 64'd0);
    check("t6_rst_ready", 64'(req_ready), 64'd0);
    s_rst = 1'b1; s_valid = '0; s_resend = 1'b0; tick();

    // Randomized traffic against the scoreboard
    for (int n = 0; n < 600; n++) begin
      s_valid  = NR'($urandom);
      s_inj    = ($urandom_range(0, 4) != 0);
      s_resend = ($urandom_range(0, 2) == 0);
      s_rst    = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < NR; i++) set_req(i, AW'($urandom), PL'({$urandom, $urandom}));
      s_ipe = ($urandom_range(0, 1) == 1) ? {1'b1, (PS-1)'({$urandom, $urandom})} : '0;
      tick();
    end
    s_rst = 1'b1; s_valid = '0; s_resend = 1'b0; s_ipe = '0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
